// File: rtl/decode_stage.sv
// Tartaruga decode stage: RV32I ALU decode, RAW scoreboard and 2-entry skid buffer.
// Define TARTARUGA_DECODE_MUL_EN to decode the M-extension ops as legal.
package decode_stage_pkg;

  typedef logic [31:0] bus32_t;

  localparam logic [6:0] OP_ALU_I = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [6:0] func7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] func3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  typedef union packed {
    rtype_t rtype;
    bus32_t raw;
  } instruction_t;

  typedef enum logic { RS1 = 1'b0, PC  = 1'b1 } rs1_or_pc_t;
  typedef enum logic { RS2 = 1'b0, IMM = 1'b1 } rs2_or_imm_t;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_op_t;

  typedef struct packed {
    bus32_t       pc;
    instruction_t instr;
    logic [4:0]   addr_rs1;
    logic [4:0]   addr_rs2;
    logic [4:0]   addr_rd;
    rs1_or_pc_t   rs1_or_pc;
    rs2_or_imm_t  rs2_or_imm;
    logic         write_enable;
    alu_op_t      alu_op;
  } instr_data_t;

  typedef struct packed {
    instr_data_t data;
    logic        illegal;
  } skid_entry_t;

endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  bus32_t             pc_i,
  input  instruction_t       instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output instr_data_t        instr_decoded_o,
  output logic               illegal_o,
  input  logic               wb_valid_i,
  input  logic [4:0]         wb_rd_i,
  input  logic               flush_i,
  output logic [NREGS-1:0]   sb_busy_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  instr_data_t      w_dec;
  logic             w_illegal;
  logic             w_uses_rs2;
  logic             w_hazard;
  logic             w_push;
  logic             w_pop;
  logic             w_tail;
  logic             w_kill_head;
  logic             w_kill_next;
  logic [CNT_W-1:0] w_cnt_rs1;
  logic [CNT_W-1:0] w_cnt_rs2;
  logic [CNT_W-1:0] w_cnt_rd;
  logic [CNT_W-1:0] w_cnt_next [NREGS];

  skid_entry_t      r_buf [2];
  logic             r_head;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_cnt [NREGS];

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    w_dec              = '0;
    w_dec.pc           = pc_i;
    w_dec.instr        = instr_i;
    w_dec.addr_rs1     = instr_i.rtype.rs1;
    w_dec.addr_rs2     = instr_i.rtype.rs2;
    w_dec.addr_rd      = instr_i.rtype.rd;
    w_dec.rs1_or_pc    = RS1;
    w_dec.rs2_or_imm   = RS2;
    w_dec.write_enable = 1'b0;
    w_dec.alu_op       = ADD;
    w_illegal          = 1'b0;

    case (instr_i.rtype.opcode)
      OP_ALU_I: begin
        w_dec.rs2_or_imm   = IMM;
        w_dec.write_enable = 1'b1;
        w_dec.addr_rs2     = '0;
        case (instr_i.rtype.func3)
          3'b000: w_dec.alu_op = ADD;
          3'b010: w_dec.alu_op = SLT;
          3'b011: w_dec.alu_op = SLTU;
          3'b100: w_dec.alu_op = XOR;
          3'b110: w_dec.alu_op = OR;
          3'b111: w_dec.alu_op = AND;
          3'b001: begin
            if (instr_i.rtype.func7 == F7_BASE) w_dec.alu_op = SLL;
            else                                w_illegal    = 1'b1;
          end
          default: begin
            if      (instr_i.rtype.func7 == F7_BASE) w_dec.alu_op = SRL;
            else if (instr_i.rtype.func7 == F7_ALT)  w_dec.alu_op = SRA;
            else                                     w_illegal    = 1'b1;
          end
        endcase
      end
      OP_ALU: begin
        w_dec.write_enable = 1'b1;
        case (instr_i.rtype.func7)
          F7_BASE: begin
            case (instr_i.rtype.func3)
              3'b000:  w_dec.alu_op = ADD;
              3'b001:  w_dec.alu_op = SLL;
              3'b010:  w_dec.alu_op = SLT;
              3'b011:  w_dec.alu_op = SLTU;
              3'b100:  w_dec.alu_op = XOR;
              3'b101:  w_dec.alu_op = SRL;
              3'b110:  w_dec.alu_op = OR;
              default: w_dec.alu_op = AND;
            endcase
          end
          F7_ALT: begin
            if      (instr_i.rtype.func3 == 3'b000) w_dec.alu_op = SUB;
            else if (instr_i.rtype.func3 == 3'b101) w_dec.alu_op = SRA;
            else                                    w_illegal    = 1'b1;
          end
`ifdef TARTARUGA_DECODE_MUL_EN
          F7_MUL: begin
            case (instr_i.rtype.func3)
              3'b000:  w_dec.alu_op = MUL;
              3'b001:  w_dec.alu_op = MULH;
              3'b010:  w_dec.alu_op = MULHSU;
              3'b011:  w_dec.alu_op = MULHU;
              3'b100:  w_dec.alu_op = DIV;
              3'b101:  w_dec.alu_op = DIVU;
              3'b110:  w_dec.alu_op = REM;
              default: w_dec.alu_op = REMU;
            endcase
          end
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        w_dec.addr_rs1     = '0;
        w_dec.rs2_or_imm   = IMM;
        w_dec.write_enable = 1'b1;
      end
      OP_AUIPC: begin
        w_dec.addr_rs1     = '0;
        w_dec.rs1_or_pc    = PC;
        w_dec.rs2_or_imm   = IMM;
        w_dec.write_enable = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase

    // Illegal encodings still travel downstream, but as a harmless NOP.
    if (w_illegal) begin
      w_dec.addr_rs1     = '0;
      w_dec.addr_rs2     = '0;
      w_dec.addr_rd      = '0;
      w_dec.rs1_or_pc    = RS1;
      w_dec.rs2_or_imm   = RS2;
      w_dec.write_enable = 1'b0;
      w_dec.alu_op       = ADD;
    end
  end

  assign w_uses_rs2 = !w_illegal && (instr_i.rtype.opcode == OP_ALU);
  assign w_cnt_rs1  = r_cnt[w_dec.addr_rs1];
  assign w_cnt_rs2  = r_cnt[w_dec.addr_rs2];
  assign w_cnt_rd   = r_cnt[w_dec.addr_rd];

  assign w_hazard = ((w_dec.addr_rs1 != '0) && (w_cnt_rs1 != '0))
                 || (w_uses_rs2 && (w_dec.addr_rs2 != '0) && (w_cnt_rs2 != '0))
                 || (w_dec.write_enable && (w_dec.addr_rd != '0) && (w_cnt_rd == CNT_MAX));

  // Ready never looks at out_ready_i, so execute stalls cannot reach fetch combinationally.
  assign in_ready_o  = (r_count != 2'd2) && !flush_i && !(in_valid_i && w_hazard);
  assign out_valid_o = (r_count != 2'd0);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_tail      = r_head ^ r_count[0];

  assign instr_decoded_o = r_buf[r_head].data;
  assign illegal_o       = r_buf[r_head].illegal;

  // Entries dropped by a flush were never issued, so their increments are undone here.
  assign w_kill_head = flush_i && (r_count != 2'd0) && !w_pop;
  assign w_kill_next = flush_i && (r_count == 2'd2);

  always_comb begin
    w_cnt_next[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      int v;
      v = int'(r_cnt[r]);
      if (w_push && w_dec.write_enable && (int'(w_dec.addr_rd) == r)) v = v + 1;
      if (wb_valid_i && (int'(wb_rd_i) == r)) v = v - 1;
      if (w_kill_head && r_buf[r_head].data.write_enable
          && (int'(r_buf[r_head].data.addr_rd) == r)) v = v - 1;
      if (w_kill_next && r_buf[~r_head].data.write_enable
          && (int'(r_buf[~r_head].data.addr_rd) == r)) v = v - 1;
      if (v < 0) v = 0;
      w_cnt_next[r] = CNT_W'(v);
    end
  end

  always_comb begin
    sb_busy_o = '0;
    for (int r = 0; r < NREGS; r++) sb_busy_o[r] = (r_cnt[r] != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
      // NOTE: the skid entries are reset because the head drives the outputs even when empty.
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) r_cnt[r] <= w_cnt_next[r];
      if (flush_i) begin
        r_head  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_push) r_buf[w_tail] <= '{data: w_dec, illegal: w_illegal};
        if (w_pop)  r_head <= ~r_head;
        r_count <= r_count + 2'(w_push) - 2'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of decoded entries plus per-feature tasks.
module tb_decode_stage;
  import decode_stage_pkg::*;

`ifdef TARTARUGA_DECODE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    instr_data_t d;
    logic        ill;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  bus32_t       pc_i;
  instruction_t instr_i;
  logic         out_valid_o;
  logic         out_ready_i;
  instr_data_t  instr_decoded_o;
  logic         illegal_o;
  logic         wb_valid_i;
  logic [4:0]   wb_rd_i;
  logic         flush_i;
  logic [31:0]  sb_busy_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t q [$];

  decode_stage #(.NREGS(32), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .instr_i(instr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_decoded_o(instr_decoded_o), .illegal_o(illegal_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .flush_i(flush_i), .sb_busy_o(sb_busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic alu_op_t base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return ADD;
      3'd1: return SLL;
      3'd2: return SLT;
      3'd3: return SLTU;
      3'd4: return XOR;
      3'd5: return SRL;
      3'd6: return OR;
      default: return AND;
    endcase
  endfunction

  function automatic alu_op_t mul_op(input logic [2:0] f3);
    case (f3)
      3'd0: return MUL;
      3'd1: return MULH;
      3'd2: return MULHSU;
      3'd3: return MULHU;
      3'd4: return DIV;
      3'd5: return DIVU;
      3'd6: return REM;
      default: return REMU;
    endcase
  endfunction

  // Reference decode, organised as "legality first, then fields".
  function automatic exp_t model(input logic [31:0] raw, input logic [31:0] pc);
    exp_t       e;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    op = raw[6:0];
    f3 = raw[14:12];
    f7 = raw[31:25];
    e = '0;
    e.d.pc    = pc;
    e.d.instr = raw;
    ok = 1'b1;
    case (op)
      7'h13: begin
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        if (f3 == 3'd5 && f7 == 7'h20) e.d.alu_op = SRA;
        else                           e.d.alu_op = base_op(f3);
        e.d.addr_rs1 = raw[19:15];
        e.d.addr_rd  = raw[11:7];
        e.d.rs2_or_imm = IMM;
        e.d.write_enable = 1'b1;
      end
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
          || (f7 == 7'h01 && MUL_EN);
        if (f7 == 7'h01)      e.d.alu_op = mul_op(f3);
        else if (f7 == 7'h20) e.d.alu_op = (f3 == 3'd0) ? SUB : SRA;
        else                  e.d.alu_op = base_op(f3);
        e.d.addr_rs1 = raw[19:15];
        e.d.addr_rs2 = raw[24:20];
        e.d.addr_rd  = raw[11:7];
        e.d.write_enable = 1'b1;
      end
      7'h37, 7'h17: begin
        e.d.addr_rs2 = raw[24:20];
        e.d.addr_rd  = raw[11:7];
        e.d.rs2_or_imm = IMM;
        e.d.write_enable = 1'b1;
        if (op == 7'h17) e.d.rs1_or_pc = PC;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0;
      e.d.pc    = pc;
      e.d.instr = raw;
      e.ill     = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard: compare on every output handshake, record on every accept.
  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        n_checks++;
        if (q.size() == 0) begin
          $display("FAIL sb_unexpected: got %h illegal=%0b, expected nothing", instr_decoded_o, illegal_o);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({instr_decoded_o, illegal_o} !== {e.d, e.ill})
            $display("FAIL sb_entry: got %h/%0b, expected %h/%0b", instr_decoded_o, illegal_o, e.d, e.ill);
          else
            n_pass++;
        end
      end
      if (flush_i) q.delete();
      if (in_valid_i && in_ready_o) q.push_back(model(instr_i, pc_i));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] raw, input logic [31:0] pc);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    instr_i    = raw;
    pc_i       = pc;
    #1;
    while (!in_ready_o && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (!in_ready_o) $display("FAIL send_timeout: instr %h never accepted", raw);
    else             n_pass++;
    step();
    in_valid_i = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid_i = 1'b1;
    wb_rd_i    = rd;
    step();
    wb_valid_i = 1'b0;
    wb_rd_i    = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready_i = 1'b1;
    while ((out_valid_o || q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    n_checks++;
    if (out_valid_o || q.size() != 0)
      $display("FAIL drain: out_valid=%0b pending=%0d, expected empty", out_valid_o, q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; in_valid_i = 1'b0; instr_i = '0; pc_i = '0; out_ready_i = 1'b1;
    wb_valid_i = 1'b0; wb_rd_i = '0; flush_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    #1;
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b, expected 0", out_valid_o); else n_pass++;
    n_checks++; if (illegal_o !== 1'b0) $display("FAIL reset_illegal: got %0b, expected 0", illegal_o); else n_pass++;
    n_checks++; if (instr_decoded_o !== '0) $display("FAIL reset_decoded: got %h, expected 0", instr_decoded_o); else n_pass++;
    n_checks++; if (sb_busy_o !== '0) $display("FAIL reset_busy: got %h, expected 0", sb_busy_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL reset_ready: got %0b, expected 1", in_ready_o); else n_pass++;
  endtask

  task automatic test_addi();
    send(32'h00500093, 32'h100);
    n_checks++; if (out_valid_o !== 1'b1) $display("FAIL addi_valid: got %0b, expected 1", out_valid_o); else n_pass++;
    n_checks++; if (instr_decoded_o.alu_op !== ADD || instr_decoded_o.rs2_or_imm !== IMM || instr_decoded_o.addr_rd !== 5'd1)
      $display("FAIL addi_fields: got op=%0d imm=%0d rd=%0d, expected ADD IMM 1", instr_decoded_o.alu_op, instr_decoded_o.rs2_or_imm, instr_decoded_o.addr_rd);
    else n_pass++;
    n_checks++; if (illegal_o !== 1'b0) $display("FAIL addi_illegal: got %0b, expected 0", illegal_o); else n_pass++;
    n_checks++; if (sb_busy_o[1] !== 1'b1) $display("FAIL addi_busy: got %0b, expected 1", sb_busy_o[1]); else n_pass++;
    wb(5'd1);
    n_checks++; if (sb_busy_o !== '0) $display("FAIL addi_retire: got %h, expected 0", sb_busy_o); else n_pass++;
  endtask

  task automatic test_raw_hazard();
    send(32'h00500093, 32'h200);
    in_valid_i = 1'b1; instr_i = 32'h00108133; pc_i = 32'h204;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (in_ready_o !== 1'b0) $display("FAIL raw_stall%0d: in_ready got %0b, expected 0", i, in_ready_o); else n_pass++;
      step();
    end
    wb_valid_i = 1'b1; wb_rd_i = 5'd1;
    #1;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL raw_no_bypass: in_ready got %0b, expected 0", in_ready_o); else n_pass++;
    step();
    wb_valid_i = 1'b0; wb_rd_i = '0;
    #1;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL raw_release: in_ready got %0b, expected 1", in_ready_o); else n_pass++;
    step();
    in_valid_i = 1'b0;
    n_checks++; if (sb_busy_o[2:1] !== 2'b10) $display("FAIL raw_counters: busy[2:1] got %b, expected 10", sb_busy_o[2:1]); else n_pass++;
    wb(5'd2);
    n_checks++; if (sb_busy_o !== '0) $display("FAIL raw_retire: got %h, expected 0", sb_busy_o); else n_pass++;
  endtask

  task automatic test_sub_illegal();
    send(32'h401101b3, 32'h300);
    n_checks++; if (instr_decoded_o.alu_op !== SUB) $display("FAIL sub_op: got %0d, expected SUB", instr_decoded_o.alu_op); else n_pass++;
    wb(5'd3);
    send(32'h421101b3, 32'h304);
    n_checks++; if (illegal_o !== 1'b1 || instr_decoded_o.write_enable !== 1'b0)
      $display("FAIL bad_f7: got illegal=%0b we=%0b, expected 1/0", illegal_o, instr_decoded_o.write_enable);
    else n_pass++;
    n_checks++; if ({instr_decoded_o.addr_rs1, instr_decoded_o.addr_rs2, instr_decoded_o.addr_rd} !== 15'd0)
      $display("FAIL bad_f7_addr: got %0d/%0d/%0d, expected 0/0/0", instr_decoded_o.addr_rs1, instr_decoded_o.addr_rs2, instr_decoded_o.addr_rd);
    else n_pass++;
    step();
    n_checks++; if (sb_busy_o !== '0) $display("FAIL bad_f7_busy: got %h, expected 0", sb_busy_o); else n_pass++;
  endtask

  task automatic test_decode_table();
    logic [31:0] tbl [6];
    exp_t        e;
    tbl[0] = 32'h4020d213;  // srai x4,x1,2
    tbl[1] = 32'h40209213;  // slli with bad func7
    tbl[2] = 32'h12345537;  // lui x10
    tbl[3] = 32'h00001597;  // auipc x11
    tbl[4] = 32'h00000003;  // load opcode
    tbl[5] = 32'h0020f6b3;  // and x13,x1,x2
    for (int i = 0; i < 6; i++) begin
      send(tbl[i], 32'h400 + 32'(i * 4));
      e = model(tbl[i], 32'h400 + 32'(i * 4));
      if (e.d.write_enable && e.d.addr_rd != '0) wb(e.d.addr_rd);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; instr_i = 32'h00100293; pc_i = 32'h500;
    #1;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL bp_ready0: got %0b, expected 1", in_ready_o); else n_pass++;
    step();
    instr_i = 32'h00200313; pc_i = 32'h504;
    #1;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL bp_ready1: got %0b, expected 1", in_ready_o); else n_pass++;
    step();
    instr_i = 32'h00300393; pc_i = 32'h508;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (in_ready_o !== 1'b0) $display("FAIL bp_full%0d: in_ready got %0b, expected 0", i, in_ready_o); else n_pass++;
      n_checks++; if (out_valid_o !== 1'b1 || instr_decoded_o.pc !== 32'h500 || instr_decoded_o.addr_rd !== 5'd5)
        $display("FAIL bp_hold%0d: got valid=%0b pc=%h rd=%0d, expected 1/500/5", i, out_valid_o, instr_decoded_o.pc, instr_decoded_o.addr_rd);
      else n_pass++;
      step();
    end
    out_ready_i = 1'b1;
    #1;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL bp_no_comb_path: in_ready got %0b, expected 0", in_ready_o); else n_pass++;
    step();
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL bp_reopen: in_ready got %0b, expected 1", in_ready_o); else n_pass++;
    step();
    in_valid_i = 1'b0;
    drain();
    wb(5'd5); wb(5'd6); wb(5'd7);
    n_checks++; if (sb_busy_o !== '0) $display("FAIL bp_retire: got %h, expected 0", sb_busy_o); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    send(32'h00100293, 32'h600);
    send(32'h00200293, 32'h604);
    n_checks++; if (out_valid_o !== 1'b1 || sb_busy_o[5] !== 1'b1)
      $display("FAIL flush_pre: got valid=%0b busy5=%0b, expected 1/1", out_valid_o, sb_busy_o[5]);
    else n_pass++;
    flush_i = 1'b1; in_valid_i = 1'b1; instr_i = 32'h00100313; pc_i = 32'h608;
    #1;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL flush_blocks: in_ready got %0b, expected 0", in_ready_o); else n_pass++;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL flush_valid: got %0b, expected 0", out_valid_o); else n_pass++;
    n_checks++; if (sb_busy_o !== '0) $display("FAIL flush_busy: got %h, expected 0", sb_busy_o); else n_pass++;
    out_ready_i = 1'b1;
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 3; i++) send((32'(i) << 20) | 32'h00000413, 32'h700 + 32'(i * 4));
    in_valid_i = 1'b1; instr_i = 32'h00400413; pc_i = 32'h710;
    #1;
    n_checks++; if (in_ready_o !== 1'b0) $display("FAIL sat_block: in_ready got %0b, expected 0", in_ready_o); else n_pass++;
    wb_valid_i = 1'b1; wb_rd_i = 5'd8;
    step();
    wb_valid_i = 1'b0; wb_rd_i = '0;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL sat_release: in_ready got %0b, expected 1", in_ready_o); else n_pass++;
    step();
    in_valid_i = 1'b0;
    wb(5'd8); wb(5'd8); wb(5'd8);
    wb(5'd8);  // extra retire at zero must be ignored
    send(32'h00100413, 32'h720);
    n_checks++; if (sb_busy_o[8] !== 1'b1) $display("FAIL sat_zero_dec: busy8 got %0b, expected 1", sb_busy_o[8]); else n_pass++;
    wb(5'd8);
    n_checks++; if (sb_busy_o !== '0) $display("FAIL sat_retire: got %h, expected 0", sb_busy_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      in_valid_i = 1'b1;
      instr_i    = (32'(i) << 20) | (32'(10 + i) << 7) | 32'h13;
      pc_i       = 32'h800 + 32'(i * 4);
      #1;
      n_checks++; if (in_ready_o !== 1'b1) $display("FAIL b2b_ready%0d: got %0b, expected 1", i, in_ready_o); else n_pass++;
      step();
    end
    in_valid_i = 1'b0;
    drain();
    for (int i = 0; i < 6; i++) wb(5'(10 + i));
    n_checks++; if (sb_busy_o !== '0) $display("FAIL b2b_retire: got %h, expected 0", sb_busy_o); else n_pass++;
  endtask

  task automatic test_mul();
    send(32'h022081b3, 32'h900);
    n_checks++;
    if (MUL_EN) begin
      if (illegal_o !== 1'b0 || instr_decoded_o.alu_op !== MUL)
        $display("FAIL mul_op: got illegal=%0b op=%0d, expected 0/MUL", illegal_o, instr_decoded_o.alu_op);
      else n_pass++;
      wb(5'd3);
    end else begin
      if (illegal_o !== 1'b1) $display("FAIL mul_illegal: got %0b, expected 1", illegal_o);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    out_ready_i = 1'b0;
    send(32'h00100293, 32'hA00);
    send(32'h00200293, 32'hA04);
    rst_i = 1'b1; flush_i = 1'b1; wb_valid_i = 1'b1; wb_rd_i = 5'd9;
    in_valid_i = 1'b1; instr_i = 32'h00100313; out_ready_i = 1'b1;
    step();
    rst_i = 1'b0; flush_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0; in_valid_i = 1'b0;
    #1;
    n_checks++; if (out_valid_o !== 1'b0 || illegal_o !== 1'b0 || instr_decoded_o !== '0)
      $display("FAIL mid_reset_out: got valid=%0b ill=%0b dec=%h, expected zeros", out_valid_o, illegal_o, instr_decoded_o);
    else n_pass++;
    n_checks++; if (sb_busy_o !== '0) $display("FAIL mid_reset_busy: got %h, expected 0", sb_busy_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw_hazard();
    test_sub_illegal();
    test_decode_table();
    test_backpressure();
    test_flush();
    test_saturation();
    test_back_to_back();
    test_mul();
    drain();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked decode stage for the tartaruga pipeline, sitting between fetch and execute. It decodes the full RV32I integer-ALU subset (OP_ALU_I, OP_ALU, OP_LUI, OP_AUIPC) into `instr_data_t` and flags illegal encodings. It holds back RAW hazards with a per-register in-flight counter scoreboard, and buffers output in a 2-entry skid buffer so execute back-pressure never creates a combinational path to fetch's ready.

## Interface

Parameters:
- `NREGS`, 32: architectural registers tracked; x0 is never tracked.
- `CNT_W`, 2: width of each in-flight counter; at most 2^CNT_W-1 outstanding writes per register.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `in_valid_i` in 1: fetch presents an instruction.
- `in_ready_o` out 1: the stage accepts this cycle.
- `pc_i` in `bus32_t`: PC of the presented instruction.
- `instr_i` in `instruction_t`: raw instruction.
- `out_valid_o` out 1: `instr_decoded_o` is valid.
- `out_ready_i` in 1: execute accepts.
- `instr_decoded_o` out `instr_data_t`: decoded head entry.
- `illegal_o` out 1: the head entry was an illegal encoding; qualified by `out_valid_o`.
- `wb_valid_i` in 1: a writeback retires this cycle.
- `wb_rd_i` in 5: destination of the retiring writeback.
- `flush_i` in 1: discard all buffered entries.
- `sb_busy_o` out `NREGS`: bit r = (counter[r] != 0).

## Operation

- Field mapping as the existing decode: `pc`, `instr`, `addr_rs1/rs2/rd` from the rtype fields.
- OP_ALU_I: rs2_or_imm=IMM, write_enable=1, addr_rs2 forced 0.
  - func3 ADDI/SLTI/SLTIU/XORI/ORI/ANDI map to ADD/SLT/SLTU/XOR/OR/AND.
  - SLLI requires func7=0000000. SRLI/SRAI require func7 0000000/0100000.
- OP_ALU: rs2_or_imm=RS2. Each func3 maps with func7=0000000. func7=0100000 is legal only for ADD→SUB and SRL→SRA.
- OP_LUI: addr_rs1=0, IMM, ADD.
- OP_AUIPC: rs1_or_pc=PC, IMM, ADD, addr_rs1=0.
- Illegal encodings (any other opcode, func3 or func7) produce a NOP: write_enable=0, RS1/RS2, addresses 0, ADD, with `illegal` set. Illegal entries still flow downstream.
- `alu_op_t` is extended with SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (plus the MUL ops under Configuration).
- Hazard: asserted when a source actually used by the instruction (rs1 unless forced 0; rs2 only for OP_ALU) is nonzero with its counter nonzero, OR when write_enable && rd!=0 && counter[rd] is saturated.
- Skid buffer: 2 entries, FIFO order; head drives the outputs.
- `in_ready_o` = !skid_full && !(in_valid_i && hazard). This depends combinationally on `instr_i` and the scoreboard only, never on `out_ready_i`.
- Accept (in_valid_i && in_ready_o): write the decoded entry to the tail. If write_enable && rd!=0, increment counter[rd].
- Writeback: wb_valid_i && wb_rd_i!=0 decrements counter[wb_rd_i]. Decrementing a zero counter is ignored.
- Increment and decrement of the same register in the same cycle leave the counter unchanged.
- Hazard uses the registered counters; there is no same-cycle writeback bypass.
- flush_i: empties the skid buffer next edge and blocks acceptance this cycle. Scoreboard counters of already-issued entries are kept. Counters of flushed, never-issued entries are decremented on flush, so every increment is matched exactly once.

## Timing

- Reset: out_valid_o=0, illegal_o=0, instr_decoded_o all-zero (NOP fields), skid empty, all counters 0, sb_busy_o=0, in_ready_o=1 when idle.
- Latency: accepted at edge N, visible on the outputs after edge N (out_valid_o=1 in cycle N+1).
- Throughput: 1/cycle with out_ready_i held high.
- When out_ready_i drops, up to 2 entries are held and in_ready_o falls the cycle after the buffer fills.
- Output hold: while out_valid_o && !out_ready_i, instr_decoded_o and illegal_o stay stable.
- Hazard release: a writeback at edge N clears the hazard; the stalled instruction is accepted at edge N+1 at the earliest.
- Reset mid-operation: the next edge returns to the reset state regardless of flush, wb or handshake inputs.

## Configuration

- `TARTARUGA_DECODE_MUL_EN` defined: OP_ALU with func7=0000001 decodes to MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by func3.
- Undefined: these encodings are illegal NOPs with illegal_o=1.

## Test plan

- Reset, then present 0x00500093 (ADDI x1,x0,5) -> next cycle out_valid_o=1, alu_op=ADD, IMM, rd=1, illegal_o=0; sb_busy_o[1]=1.
- 0x00500093 then 0x00108133 (ADD x2,x1,x1) -> in_ready_o=0 until wb_valid_i/wb_rd_i=1. After the writeback edge, ADD is accepted at the following edge; counter[1] returns to 0.
- 0x401101b3 (SUB x3,x2,x1) with no pending writes -> alu_op=SUB. 0x421101b3 (bad func7) -> illegal_o=1, write_enable=0, addresses 0.
- Hold out_ready_i=0 while streaming 3 legal instructions -> 2 entries buffered, in_ready_o=0 from the third cycle. Release -> order preserved, no loss or duplication.
- Two buffered ADDI x5 entries, flush_i=1 -> out_valid_o=0 next cycle, counter[5]=0, sb_busy_o[5]=0.
- 0x022081b3 (MUL x3,x1,x2) -> alu_op=MUL with `TARTARUGA_DECODE_MUL_EN`; illegal_o=1 without it.
